pipe_skid: RTL and testbench
============================

# pipe_skid

Two-entry skid buffer at the consuming end of a pipeline segment built from `delay` stages. It turns the combinational downstream stall `en_n` into a registered upstream stall `stallOut`, so long stall paths through the MIPS hazard logic are cut without losing data in flight. Data is moved with a valid/stall handshake, and a synchronous flush supports branch squash.

## Interface
- `BIT_WIDTH`, 32: width of one data word.
- `DEPTH`, 1: words per transfer; the data bus is `BIT_WIDTH*DEPTH` bits.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous squash of all buffered entries.
- `validIn`  in  1  upstream word present on `dataIn`.
- `dataIn`  in  BIT_WIDTH*DEPTH  upstream data.
- `stallOut`  out  1  registered stall to upstream; 1 means this cycle's `validIn` is not accepted.
- `en_n`  in  1  downstream stall, active low enable; 1 means downstream does not take `dataOut`.
- `validOut`  out  1  `dataOut` holds a valid word.
- `dataOut`  out  BIT_WIDTH*DEPTH  head-of-buffer data, driven directly from the main register.

## Operation
- Storage: a main register (`main`) and a skid register (`skid`), each BIT_WIDTH*DEPTH bits.
- State register with three states:
  - EMPTY: no valid entries.
  - BUSY: `main` valid.
  - FULL: `main` and `skid` both valid.
- Accept = `validIn & ~stallOut`.
- Consume = `validOut & ~en_n`.
- `stallOut` = (state == FULL). It is a pure decode of the state register and is not combinationally dependent on `en_n` or `validIn`.
- `validOut` = (state != EMPTY).
- Transitions (priority rst > flush > normal):
  - EMPTY: accept -> BUSY, `main` <= `dataIn`. Otherwise stay EMPTY.
  - BUSY, accept & consume: stay BUSY, `main` <= `dataIn`.
  - BUSY, accept & ~consume: -> FULL, `skid` <= `dataIn`.
  - BUSY, ~accept & consume: -> EMPTY.
  - BUSY, neither: hold.
  - FULL: input ignored because `stallOut`=1. Consume -> BUSY, `main` <= `skid`. Otherwise hold.
- Order is strictly FIFO; no word is ever dropped or duplicated except by `flush` or `rst`.
- `flush`: next state EMPTY.
  - A `validIn` in the same cycle is discarded.
  - A consume in the same cycle still counts as completed downstream; the buffer does not retract it.
  - Data registers are not cleared.
- `main` loads only on the transitions listed above. `dataOut` holds its last loaded value while EMPTY.

## Timing
- Reset values: state EMPTY, `validOut`=0, `stallOut`=0, `dataOut`=0, `skid`=0.
- Latency: a word accepted at edge N appears on `dataOut` with `validOut`=1 after edge N, i.e. 1 cycle, when the buffer was EMPTY, or when BUSY with a simultaneous consume.
- Throughput: 1 word/cycle sustained while `en_n`=0.
- `stallOut` rises 1 cycle after the cycle in which BUSY accepted without consume.
- `stallOut` falls 1 cycle after the first consume in FULL.
- Upstream must hold `dataIn`/`validIn` stable while `stallOut`=1 if it wants the word delivered. The buffer samples input only when `stallOut`=0.
- Reset or flush mid-stream: outputs reflect EMPTY from the next edge. Upstream sees `stallOut`=0 the following cycle.
- `en_n` toggling while EMPTY has no effect.

## Structure
- Shared package `pipe_pkg`: 2-bit state encoding localparams `PS_EMPTY`=0, `PS_BUSY`=1, `PS_FULL`=2. Encoding 3 is illegal and recovers to EMPTY.
- No sub-module. Single always block for state and data registers, plus continuous assigns for `validOut`/`stallOut`.
- Drop-in at the tail of a `delay` chain: `dataOut`/`en_n` connect to the next stage's `dataIn`/`en_n`.

## Test plan
- Reset, then idle 3 cycles -> `validOut`=0, `stallOut`=0, `dataOut`=0.
- Stream 0x1..0x8 back-to-back with `en_n`=0 -> `dataOut` = 0x1..0x8 on consecutive cycles, 1-cycle latency, `stallOut` never 1.
- Send 0xA, 0xB with `en_n`=1 -> FULL, `stallOut`=1, 0xC held by upstream. Release `en_n` -> outputs 0xA, 0xB, 0xC in order with no loss.
- In FULL (holding 0xA, 0xB), assert `flush` together with `validIn`=0xC -> next cycle `validOut`=0, `stallOut`=0, 0xC not delivered.
- Assert `rst` while BUSY with `en_n`=1 -> next cycle all outputs at reset values. A subsequent word 0x5 appears 1 cycle after acceptance.
- Random `validIn`/`en_n` for 10k cycles against a scoreboard queue -> exact FIFO order, no loss or duplication, `stallOut` matches FULL every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid buffer: state encoding.
package pipe_pkg;

  // 2-bit state encoding; value 3 is unused and recovers to EMPTY
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid.sv
// Two-entry skid buffer: converts the combinational downstream stall en_n
// into a registered upstream stall, keeping strict FIFO order.
module pipe_skid
  import pipe_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int DEPTH     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       validIn,
  input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
  output logic                       stallOut,
  input  logic                       en_n,
  output logic                       validOut,
  output logic [BIT_WIDTH*DEPTH-1:0] dataOut
);

  localparam int W = BIT_WIDTH * DEPTH;

  pipe_state_e  state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         consume;

  // Stall is a pure state decode, so no combinational path from en_n upstream
  assign stallOut = (state == PS_FULL);
  assign validOut = (state != PS_EMPTY);
  assign dataOut  = main_q;

  assign accept  = validIn & ~stallOut;
  assign consume = validOut & ~en_n;

  // State and data registers; flush empties the buffer but leaves data intact
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PS_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= PS_EMPTY;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (accept) begin
            state  <= PS_BUSY;
            main_q <= dataIn;
          end
        end
        PS_BUSY: begin
          if (accept && consume) begin
            main_q <= dataIn;
          end else if (accept) begin
            skid_q <= dataIn;
            state  <= PS_FULL;
          end else if (consume) begin
            state <= PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (consume) begin
            main_q <= skid_q;
            state  <= PS_BUSY;
          end
        end
        default: state <= PS_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid.sv
// Self-checking bench for pipe_skid using a scoreboard queue model.
module tb_pipe_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        validIn;
  logic [31:0] dataIn;
  logic        stallOut;
  logic        en_n;
  logic        validOut;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_out = '0;

  pipe_skid #(.BIT_WIDTH(32), .DEPTH(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .validIn  (validIn),
    .dataIn   (dataIn),
    .stallOut (stallOut),
    .en_n     (en_n),
    .validOut (validOut),
    .dataOut  (dataOut)
  );

  always #5 clk = ~clk;

  // Reference model: queue content is what the buffer holds, front = dataOut
  task automatic model_step();
    bit m_stall;
    bit m_valid;
    bit acc;
    bit con;
    m_stall = (exp_q.size() == 2);
    m_valid = (exp_q.size() != 0);
    acc = validIn && !m_stall;
    con = m_valid && !en_n;
    if (rst) begin
      exp_q.delete();
      last_out = '0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(dataIn);
      if (exp_q.size() > 0) last_out = exp_q[0];
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit e, input bit f, input bit r);
    validIn = v;
    dataIn  = d;
    en_n    = e;
    flush   = f;
    rst     = r;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 32'h0, 1, 0, 1);
    advance();
    advance();
    drive(0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if (validOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_validOut: got %0b expected 0", validOut);
      end
      checks++;
      if (stallOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_stallOut: got %0b expected 0", stallOut);
      end
      checks++;
      if (dataOut !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_dataOut: got %0h expected 0", dataOut);
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'(i), 0, 0, 0);
      checks++;
      if (stallOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_stall: got %0b expected 0 at word %0d", stallOut, i);
      end
      if (i > 1) begin
        checks++;
        if (validOut !== 1'b1 || dataOut !== 32'(i - 1)) begin
          errors++;
          $display("[TB] FAIL stream_data: got v=%0b d=%0h expected v=1 d=%0h", validOut, dataOut, i - 1);
        end
      end
      advance();
    end
    drive(0, 32'h0, 0, 0, 0);
    checks++;
    if (validOut !== 1'b1 || dataOut !== 32'h8) begin
      errors++;
      $display("[TB] FAIL stream_last: got v=%0b d=%0h expected v=1 d=8", validOut, dataOut);
    end
    advance();
    checks++;
    if (validOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_drain: got validOut=%0b expected 0", validOut);
    end
  endtask

  task automatic test_full();
    logic [31:0] got[$];
    logic [31:0] want[3];
    bit c_taken;
    want[0] = 32'hA;
    want[1] = 32'hB;
    want[2] = 32'hC;
    drive(1, 32'hA, 1, 0, 0);
    advance();
    drive(1, 32'hB, 1, 0, 0);
    advance();
    drive(1, 32'hC, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (stallOut !== 1'b1 || validOut !== 1'b1 || dataOut !== 32'hA) begin
        errors++;
        $display("[TB] FAIL full_hold: got s=%0b v=%0b d=%0h expected s=1 v=1 d=a", stallOut, validOut, dataOut);
      end
      advance();
    end
    c_taken = 1'b0;
    en_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (validOut === 1'b1) got.push_back(dataOut);
      if (!c_taken && validIn && !stallOut) c_taken = 1'b1;
      advance();
      if (c_taken) validIn = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("[TB] FAIL full_count: got %0d words expected 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("[TB] FAIL full_order[%0d]: got %0h expected %0h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_flush();
    drive(1, 32'hA, 1, 0, 0);
    advance();
    drive(1, 32'hB, 1, 0, 0);
    advance();
    checks++;
    if (stallOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_pre_full: got stallOut=%0b expected 1", stallOut);
    end
    drive(1, 32'hC, 1, 1, 0);
    advance();
    drive(0, 32'h0, 0, 0, 0);
    checks++;
    if (validOut !== 1'b0 || stallOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_empty: got v=%0b s=%0b expected v=0 s=0", validOut, stallOut);
    end
    checks++;
    if (dataOut !== 32'hA) begin
      errors++;
      $display("[TB] FAIL flush_data_kept: got %0h expected a", dataOut);
    end
    for (int i = 0; i < 2; i++) begin
      advance();
      checks++;
      if (validOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_no_c: got validOut=%0b d=%0h expected 0", validOut, dataOut);
      end
    end
  endtask

  task automatic test_reset_busy();
    drive(1, 32'h7, 1, 0, 0);
    advance();
    drive(0, 32'h0, 1, 0, 0);
    checks++;
    if (validOut !== 1'b1 || dataOut !== 32'h7) begin
      errors++;
      $display("[TB] FAIL rbusy_pre: got v=%0b d=%0h expected v=1 d=7", validOut, dataOut);
    end
    drive(0, 32'h0, 1, 0, 1);
    advance();
    drive(1, 32'h5, 0, 0, 0);
    checks++;
    if (validOut !== 1'b0 || stallOut !== 1'b0 || dataOut !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rbusy_reset: got v=%0b s=%0b d=%0h expected 0 0 0", validOut, stallOut, dataOut);
    end
    advance();
    drive(0, 32'h0, 0, 0, 0);
    checks++;
    if (validOut !== 1'b1 || dataOut !== 32'h5) begin
      errors++;
      $display("[TB] FAIL rbusy_after: got v=%0b d=%0h expected v=1 d=5", validOut, dataOut);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    bit v;
    bit e;
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 2) == 0);
      drive(v, $urandom, e, 0, 0);
      checks++;
      if (stallOut !== (exp_q.size() == 2)) begin
        errors++;
        $display("[TB] FAIL rand_stall: got %0b expected %0b at cycle %0d", stallOut, exp_q.size() == 2, i);
      end
      checks++;
      if (validOut !== (exp_q.size() != 0)) begin
        errors++;
        $display("[TB] FAIL rand_valid: got %0b expected %0b at cycle %0d", validOut, exp_q.size() != 0, i);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (dataOut !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL rand_data: got %0h expected %0h at cycle %0d", dataOut, exp_q[0], i);
        end
      end else begin
        checks++;
        if (dataOut !== last_out) begin
          errors++;
          $display("[TB] FAIL rand_idle_data: got %0h expected %0h at cycle %0d", dataOut, last_out, i);
        end
      end
      advance();
    end
  endtask

  initial begin
    drive(0, 32'h0, 1, 0, 1);
    #1;
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_reset_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
